// File: rtl/pattern_generator_if.sv
// Load/stream bundle for pattern_generator: parallel load handshake in, serial pattern out.
interface pattern_generator_if #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int unsigned CNT_W   = 8
);
  logic               load_valid;
  logic               load_ready;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic [CNT_W-1:0]   repeat_cnt;
  logic               abort;
  logic               out;
  logic               out_valid;
  logic               frame_start;
  logic               busy;
  logic               done;

  modport master (
    output load_valid, pattern, len, repeat_cnt, abort,
    input  load_ready, out, out_valid, frame_start, busy, done
  );

  modport slave (
    input  load_valid, pattern, len, repeat_cnt, abort,
    output load_ready, out, out_valid, frame_start, busy, done
  );
endinterface

// File: rtl/pattern_generator.sv
// Serial test-pattern transmitter: shifts a loaded word out MSB-first, with optional
// repeats separated by GAP idle cycles. All outputs are registered.
module pattern_generator #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned GAP     = 0
) (
  input logic               clk,
  input logic               reset,
  pattern_generator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StGapWait} state_e;

  localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [7:0]       GapLast = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_e             state_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [CNT_W-1:0]   rep_q;
  logic [7:0]         gap_q;
  logic               out_q;
  logic               out_valid_q;
  logic               frame_start_q;
  logic               busy_q;
  logic               done_q;
  logic               load_ready_q;

  logic [LEN_W-1:0]   eff_len;

  assign eff_len = (bus.len > MaxLen) ? MaxLen : bus.len;

  // Shift-based select keeps the index width independent of MAX_LEN.
  function automatic logic bit_at(logic [MAX_LEN-1:0] p, logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pat_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      rep_q         <= '0;
      gap_q         <= '0;
      out_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      done_q        <= 1'b0;
      frame_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load_valid && !bus.abort) begin
            if (eff_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q       <= StShift;
              pat_q         <= bus.pattern;
              len_q         <= eff_len;
              rep_q         <= bus.repeat_cnt;
              idx_q         <= eff_len - LenOne;
              out_q         <= bit_at(bus.pattern, eff_len - LenOne);
              out_valid_q   <= 1'b1;
              frame_start_q <= 1'b1;
              busy_q        <= 1'b1;
              load_ready_q  <= 1'b0;
            end
          end
        end
        StShift: begin
          if (bus.abort) begin
            state_q      <= StIdle;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
          end else if (idx_q == '0) begin
            if (rep_q != '0) begin
              rep_q <= rep_q - CntOne;
              if (GAP > 0) begin
                state_q     <= StGapWait;
                gap_q       <= GapLast;
                out_q       <= 1'b0;
                out_valid_q <= 1'b0;
              end else begin
                idx_q         <= len_q - LenOne;
                out_q         <= bit_at(pat_q, len_q - LenOne);
                frame_start_q <= 1'b1;
              end
            end else begin
              state_q      <= StIdle;
              done_q       <= 1'b1;
              out_q        <= 1'b0;
              out_valid_q  <= 1'b0;
              busy_q       <= 1'b0;
              load_ready_q <= 1'b1;
            end
          end else begin
            idx_q <= idx_q - LenOne;
            out_q <= bit_at(pat_q, idx_q - LenOne);
          end
        end
        StGapWait: begin
          if (bus.abort) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b1;
          end else if (gap_q == 8'd0) begin
            state_q       <= StShift;
            idx_q         <= len_q - LenOne;
            out_q         <= bit_at(pat_q, len_q - LenOne);
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.load_ready  = load_ready_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: one GAP=3 and one GAP=0 instance, bit stream
// checked against a scoreboard of expected bits filled at load time.
module tb_pattern_generator;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned LenW   = 5;
  localparam int unsigned CntW   = 8;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pattern_generator_if #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW)) if0 ();
  pattern_generator_if #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW)) if1 ();

  pattern_generator #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW), .GAP(3)) u_gap3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  pattern_generator #(.MAX_LEN(MaxLen), .LEN_W(LenW), .CNT_W(CntW), .GAP(0)) u_gap0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  int   sel = 0;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   fs_cnt = 0;
  int   vcnt = 0;
  int   n;

  logic o_out, o_valid, o_fs, o_busy, o_done, o_ready;
  assign o_out   = (sel == 1) ? if1.out         : if0.out;
  assign o_valid = (sel == 1) ? if1.out_valid   : if0.out_valid;
  assign o_fs    = (sel == 1) ? if1.frame_start : if0.frame_start;
  assign o_busy  = (sel == 1) ? if1.busy        : if0.busy;
  assign o_done  = (sel == 1) ? if1.done        : if0.done;
  assign o_ready = (sel == 1) ? if1.load_ready  : if0.load_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    if (o_valid) begin
      vcnt++;
      chk("sb_avail", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_bit", o_out, e.b);
        chk("frame_start", o_fs, e.fs);
      end
    end
    if (o_fs) fs_cnt++;
    if (o_done) done_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, o_out, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_fs"}, o_fs, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_ready"}, o_ready, 1);
  endtask

  task automatic drive(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r);
    if0.pattern = p;    if1.pattern = p;
    if0.len = l;        if1.len = l;
    if0.repeat_cnt = r; if1.repeat_cnt = r;
  endtask

  task automatic set_lv(input logic v);
    if0.load_valid = v & (sel == 0);
    if1.load_valid = v & (sel == 1);
  endtask

  task automatic set_ab(input logic v);
    if0.abort = v & (sel == 0);
    if1.abort = v & (sel == 1);
  endtask

  // Expected stream: saturated length, MSB first, frame_start on the top bit.
  task automatic push_model(input logic [15:0] p, input int l, input int r);
    int eff;
    eff = (l > 16) ? 16 : l;
    for (int f = 0; f <= r; f++) begin
      for (int i = eff - 1; i >= 0; i--) begin
        sb.push_back('{b: p[i], fs: (i == eff - 1)});
      end
    end
  endtask

  task automatic load(input logic [15:0] p, input int l, input int r);
    drive(p, 5'(l), 8'(r));
    push_model(p, l, r);
    done_seen = 0;
    fs_cnt = 0;
    vcnt = 0;
    set_lv(1'b1);
    tick();
    set_lv(1'b0);
  endtask

  task automatic wait_done(input int n0, input int limit, output int nout);
    nout = n0;
    while (done_seen == 0 && nout < limit) begin
      tick();
      nout++;
    end
    chk("done_once", done_seen, 1);
  endtask

  initial begin
    if0.load_valid = 0; if1.load_valid = 0;
    if0.abort = 0;      if1.abort = 0;
    drive(16'h0, 5'd0, 8'd0);

    // Reset values
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sel = 0; #0 chk_idle("rst_g3");
    sel = 1; #0 chk_idle("rst_g0");

    // 9-bit 010101010, single frame
    sel = 0;
    load(16'h00AA, 9, 0);
    wait_done(1, 50, n);
    chk("a_done_cycle", n, 10);
    chk("a_fs_cnt", fs_cnt, 1);
    chk("a_vcnt", vcnt, 9);
    chk("a_sb_empty", sb.size(), 0);
    chk("a_ready_in_done", o_ready, 1);
    chk("a_busy_in_done", o_busy, 0);

    // Back-to-back load in the done cycle
    load(16'b110, 3, 0);
    wait_done(1, 50, n);
    chk("bb_done_cycle", n, 4);
    chk("bb_sb_empty", sb.size(), 0);

    // 1011 x3 with GAP=3
    tick();
    load(16'b1011, 4, 2);
    wait_done(1, 100, n);
    chk("b_done_cycle", n, 19);
    chk("b_fs_cnt", fs_cnt, 3);
    chk("b_vcnt", vcnt, 12);
    chk("b_sb_empty", sb.size(), 0);

    // 110 x2 with GAP=0: contiguous
    sel = 1;
    tick();
    load(16'b110, 3, 1);
    wait_done(1, 50, n);
    chk("c_done_cycle", n, 7);
    chk("c_vcnt", vcnt, 6);
    chk("c_fs_cnt", fs_cnt, 2);
    chk("c_sb_empty", sb.size(), 0);

    // Abort on the 3rd bit of a 9-bit frame
    sel = 0;
    tick();
    load(16'b011001110, 9, 0);
    tick();
    tick();
    set_ab(1'b1);
    tick();
    set_ab(1'b0);
    chk("ab_valid", o_valid, 0);
    chk("ab_busy", o_busy, 0);
    chk("ab_ready", o_ready, 1);
    sb.delete();
    repeat (3) tick();
    chk("ab_no_done", done_seen, 0);
    load(16'b10, 2, 0);
    wait_done(1, 50, n);
    chk("ab_reload_done", n, 3);
    chk("ab_sb_empty", sb.size(), 0);

    // Reset during GAP_WAIT
    tick();
    load(16'b11, 2, 1);
    tick();
    tick();
    chk("rg_in_gap_valid", o_valid, 0);
    chk("rg_in_gap_busy", o_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rg");
    sb.delete();
    repeat (8) tick();
    chk("rg_no_done", done_seen, 0);

    // Load while busy is ignored
    load(16'b10110, 5, 0);
    tick();
    drive(16'b01001, 5'd3, 8'd3);
    set_lv(1'b1);
    tick();
    set_lv(1'b0);
    wait_done(3, 50, n);
    chk("ib_done_cycle", n, 6);
    chk("ib_vcnt", vcnt, 5);
    chk("ib_sb_empty", sb.size(), 0);
    repeat (6) tick();
    chk("ib_single_done", done_seen, 1);

    // len=0: done next cycle, nothing sent
    load(16'hFFFF, 0, 3);
    wait_done(1, 20, n);
    chk("z_done_cycle", n, 1);
    repeat (4) tick();
    chk("z_vcnt", vcnt, 0);

    // len=31 saturates to 16
    load(16'hA5C3, 31, 0);
    wait_done(1, 50, n);
    chk("sat_done_cycle", n, 17);
    chk("sat_vcnt", vcnt, 16);
    chk("sat_sb_empty", sb.size(), 0);

    // Maximum repeat count: 256 frames
    sel = 1;
    tick();
    load(16'b01, 2, 255);
    wait_done(1, 1000, n);
    chk("mr_done_cycle", n, 513);
    chk("mr_vcnt", vcnt, 512);
    chk("mr_fs_cnt", fs_cnt, 256);
    chk("mr_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
